// File: rtl/ubi_pkg.sv
// Shared types and helpers for the unipolar/bipolar stream decoder.
package ubi_pkg;

  // Decoder control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ubi_dec_state_t;

  // Number of stream bits in one conversion window.
  function automatic int unsigned win_len(input int unsigned width);
    return 32'd1 << width;
  endfunction

endpackage

// File: rtl/ubi_win_counter.sv
// Window counter: counts accepted stream bits and accumulates the ones among them.
module ubi_win_counter
  import ubi_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             stream_bit,
  output logic             last,
  output logic [WIDTH:0]   ones
);

  localparam logic [WIDTH-1:0] LAST_IDX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] len_r;
  logic [WIDTH:0]   ones_r;

  // The Nth accepted bit is the one offered while the length counter sits at N-1.
  assign last = en && (len_r == LAST_IDX);

  // Running count including the bit offered this cycle; at last it is the final count.
  assign ones = ones_r + {{WIDTH{1'b0}}, stream_bit};

  // Length/ones counters; cleared on a new window and after the Nth bit so len never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_r  <= {WIDTH{1'b0}};
      ones_r <= {(WIDTH+1){1'b0}};
    end else if (clr || last) begin
      len_r  <= {WIDTH{1'b0}};
      ones_r <= {(WIDTH+1){1'b0}};
    end else if (en) begin
      len_r  <= len_r + WIDTH'(1'b1);
      ones_r <= ones;
    end else begin
      len_r  <= len_r;
      ones_r <= ones_r;
    end
  end

endmodule

// File: rtl/ubi_stream_decoder.sv
// Stochastic-to-binary reader: counts ones over a 2**WIDTH bit window and
// reports the count plus the bipolar value 2*ones - N.
module ubi_stream_decoder
  import ubi_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               iStart,
  input  logic               iBit,
  input  logic               iEn,
  input  logic               iReady,
  output logic               oBusy,
  output logic               oValid,
  output logic [WIDTH:0]     oOnes,
  output logic [WIDTH+1:0]   oVal
);

  localparam logic [WIDTH+1:0] N_VAL = (WIDTH+2)'(win_len(WIDTH));

  ubi_dec_state_t   state_r;
  ubi_dec_state_t   state_nx_s;
  logic             clr_s;
  logic             en_s;
  logic             last_s;
  logic [WIDTH:0]   count_s;
  logic [WIDTH+1:0] val_s;
  logic             busy_r;
  logic             valid_r;
  logic [WIDTH:0]   ones_r;
  logic [WIDTH+1:0] val_r;

  // Bits are only taken while a window is running and the stream is qualified.
  assign en_s = (state_r == RUN) && iEn;

  // Bipolar conversion in WIDTH+2 bits: 0..2N minus N stays inside -N..+N.
  assign val_s = ({1'b0, count_s} << 1) - N_VAL;

  ubi_win_counter #(
    .WIDTH(WIDTH)
  ) u_win_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr_s),
    .en         (en_s),
    .stream_bit (iBit),
    .last       (last_s),
    .ones       (count_s)
  );

  // Next-state logic; a window (re)starts from IDLE, or from DONE once the result is taken.
  always_comb begin
    state_nx_s = state_r;
    clr_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (iStart) begin
          state_nx_s = RUN;
          clr_s      = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      DONE: begin
        if (iReady && iStart) begin
          state_nx_s = RUN;
          clr_s      = 1'b1;
        end else if (iReady) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: begin
        state_nx_s = IDLE;
        clr_s      = 1'b1;
      end
    endcase
  end

  // State and registered outputs; the result registers only load on the Nth bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      ones_r  <= {(WIDTH+1){1'b0}};
      val_r   <= {(WIDTH+2){1'b0}};
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s == RUN);
      valid_r <= (state_nx_s == DONE);
      if (last_s) begin
        ones_r <= count_s;
        val_r  <= val_s;
      end else begin
        ones_r <= ones_r;
        val_r  <= val_r;
      end
    end
  end

  assign oBusy  = busy_r;
  assign oValid = valid_r;
  assign oOnes  = ones_r;
  assign oVal   = val_r;

endmodule

// File: tb/tb_ubi_stream_decoder.sv
// Directed self-checking bench for ubi_stream_decoder with WIDTH=8 (N=256).
module tb_ubi_stream_decoder;

  localparam int WIDTH  = 8;
  localparam int N      = 256;
  localparam int BUDGET = 2000;

  logic             clk;
  logic             rst_n;
  logic             iStart;
  logic             iBit;
  logic             iEn;
  logic             iReady;
  logic             oBusy;
  logic             oValid;
  logic [WIDTH:0]   oOnes;
  logic [WIDTH+1:0] oVal;

  int checks;
  int errors;
  int win_cycles;
  int busy_lo;
  int overlap;

  ubi_stream_decoder #(
    .WIDTH(WIDTH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .iStart (iStart),
    .iBit   (iBit),
    .iEn    (iEn),
    .iReady (iReady),
    .oBusy  (oBusy),
    .oValid (oValid),
    .oOnes  (oOnes),
    .oVal   (oVal)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream pattern for the k-th accepted bit.
  function automatic logic pat(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return (k % 2 == 0) ? 1'b1 : 1'b0;
      3:       return (k % 4 != 3) ? 1'b1 : 1'b0;
      default: return 1'b0;
    endcase
  endfunction

  // One-cycle start pulse from IDLE.
  task automatic start_window();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
  endtask

  // Feed a window until oValid (bounded); optional 50% iEn duty.
  task automatic feed(input int mode, input bit stall);
    int  k;
    int  cyc;
    logic en;
    k = 0;
    cyc = 0;
    busy_lo = 0;
    overlap = 0;
    while (!oValid && cyc < BUDGET) begin
      en   = stall ? ((cyc % 2 == 0) ? 1'b1 : 1'b0) : 1'b1;
      iEn  = en;
      iBit = pat(mode, k);
      tick();
      cyc++;
      if (en) k++;
      if (!oValid && !oBusy) busy_lo++;
      if (oValid && oBusy) overlap++;
    end
    iEn  = 1'b0;
    iBit = 1'b0;
    win_cycles = cyc;
    check("valid_reached", int'(oValid), 1);
  endtask

  // Check a finished window and the busy/valid relationship during it.
  task automatic check_result(input string tag, input int cycles, input int ones, input int val);
    check({tag, "_cycles"}, win_cycles, cycles);
    check({tag, "_ones"}, int'(oOnes), ones);
    check({tag, "_val"}, int'($signed(oVal)), val);
    check({tag, "_busy_done"}, int'(oBusy), 0);
    check({tag, "_busy_run"}, busy_lo, 0);
    check({tag, "_overlap"}, overlap, 0);
  endtask

  // Accept a result with iReady and no new start; outputs must be retained.
  task automatic release_result(input string tag, input int ones, input int val);
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    check({tag, "_valid_drop"}, int'(oValid), 0);
    check({tag, "_hold_ones"}, int'(oOnes), ones);
    check({tag, "_hold_val"}, int'($signed(oVal)), val);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    iStart = 1'b0;
    iBit   = 1'b0;
    iEn    = 1'b0;
    iReady = 1'b0;
    tick();
    tick();
    check("rst_busy", int'(oBusy), 0);
    check("rst_valid", int'(oValid), 0);
    check("rst_ones", int'(oOnes), 0);
    check("rst_val", int'($signed(oVal)), 0);
    rst_n = 1'b1;
    tick();

    // All ones: valid in cycle N+1 after the start cycle (N ticks after the start edge).
    iEn = 1'b1;
    start_window();
    check("start_busy", int'(oBusy), 1);
    feed(0, 1'b0);
    check_result("ones", N, 256, 256);
    release_result("ones", 256, 256);

    // All zeros.
    start_window();
    feed(1, 1'b0);
    check_result("zeros", N, 0, -256);
    release_result("zeros", 0, -256);

    // Alternating 1,0.
    start_window();
    feed(2, 1'b0);
    check_result("alt", N, 128, 0);
    release_result("alt", 128, 0);

    // Pattern 1,1,1,0.
    start_window();
    feed(3, 1'b0);
    check_result("p1110", N, 192, 128);
    release_result("p1110", 192, 128);

    // 50% iEn duty, all ones: 256 accepted bits take 511 cycles.
    start_window();
    feed(0, 1'b1);
    check_result("stall", 2 * N - 1, 256, 256);

    // Backpressure: result held, start and stream ignored while iReady=0.
    for (int i = 0; i < 5; i++) begin
      iReady = 1'b0;
      iStart = 1'b1;
      iEn    = 1'b1;
      iBit   = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      check("bp_valid", int'(oValid), 1);
      check("bp_busy", int'(oBusy), 0);
      check("bp_ones", int'(oOnes), 256);
      check("bp_val", int'($signed(oVal)), 256);
    end
    // Back-to-back: iReady with iStart restarts immediately.
    iReady = 1'b1;
    iStart = 1'b1;
    iEn    = 1'b0;
    tick();
    iReady = 1'b0;
    iStart = 1'b0;
    check("b2b_busy", int'(oBusy), 1);
    check("b2b_valid", int'(oValid), 0);
    feed(3, 1'b0);
    check_result("b2b", N, 192, 128);
    release_result("b2b", 192, 128);

    // Reset mid-window after 100 accepted ones.
    start_window();
    for (int i = 0; i < 100; i++) begin
      iEn  = 1'b1;
      iBit = 1'b1;
      tick();
    end
    iEn   = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mrst_busy", int'(oBusy), 0);
    check("mrst_valid", int'(oValid), 0);
    check("mrst_ones", int'(oOnes), 0);
    check("mrst_val", int'($signed(oVal)), 0);
    tick();
    check("mrst_idle", int'(oBusy), 0);
    start_window();
    feed(2, 1'b0);
    check_result("post_rst", N, 128, 0);
    release_result("post_rst", 128, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
